// File: rtl/kv_csa_pkg.sv
// Shared types and sizing helpers for the carry-save resolver.
// State encodings plus chunk-count and chunk-index width functions.
package kv_csa_pkg;

   localparam logic [1:0] KV_IDLE = 2'd0;
   localparam logic [1:0] KV_ADD  = 2'd1;
   localparam logic [1:0] KV_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = KV_IDLE,
      ADD  = KV_ADD,
      DONE = KV_DONE
   } kv_state_t;

   function automatic int kv_csa_nchunk(int width, int chunk);
      return width / chunk;
   endfunction

   function automatic int kv_csa_kw(int width, int chunk);
      int n;
      n = kv_csa_nchunk(width, chunk);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/kv_csa_resolve_if.sv
// Operand and result handshake bundle for kv_csa_resolve.
// out_zero exists only when KV_CSA_RESOLVE_ZERO_FLAG_EN is defined.
interface kv_csa_resolve_if #(
   parameter int WIDTH = 32
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic [WIDTH-1:0] in_carry;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_sign;
`ifdef KV_CSA_RESOLVE_ZERO_FLAG_EN
   logic             out_zero;
`endif

   modport master (
`ifdef KV_CSA_RESOLVE_ZERO_FLAG_EN
      input  out_zero,
`endif
      output in_valid, in_sum, in_carry, in_cin, out_ready,
      input  in_ready, out_valid, out_result, out_sign
   );

   modport slave (
`ifdef KV_CSA_RESOLVE_ZERO_FLAG_EN
      output out_zero,
`endif
      input  in_valid, in_sum, in_carry, in_cin, out_ready,
      output in_ready, out_valid, out_result, out_sign
   );

endinterface

// File: rtl/kv_csa_chunk_add.sv
// Combinational CHUNK-bit adder slice used by the resolver.
module kv_csa_chunk_add #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/kv_csa_resolve.sv
// Chunked carry-propagate resolver: {sum, carry} -> binary, CHUNK bits/cycle.
// Optional out_zero flag under KV_CSA_RESOLVE_ZERO_FLAG_EN.
module kv_csa_resolve
   import kv_csa_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                core_clk,
   input  logic                core_reset_n,
   input  logic                flush,
   kv_csa_resolve_if.slave     bus
);

   localparam int NCHUNK = kv_csa_nchunk(WIDTH, CHUNK);
   localparam int KW     = kv_csa_kw(WIDTH, CHUNK);
   localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

   kv_state_t        state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] res_q;
   logic             c_q;
   logic [KW-1:0]    k_q;
   logic             valid_q;
   logic             sign_q;
   logic [CHUNK-1:0] s;
   logic             co;
   logic [WIDTH-1:0] acc_nx;
`ifdef KV_CSA_RESOLVE_ZERO_FLAG_EN
   logic             zacc_q;
   logic             zero_q;
`endif

   kv_csa_chunk_add #(.CHUNK(CHUNK)) u_add (
      .a  (a_q[CHUNK-1:0]),
      .b  (b_q[CHUNK-1:0]),
      .ci (c_q),
      .s  (s),
      .co (co)
   );

   // new chunk enters at the MSB; after NCHUNK shifts it is fully aligned
   assign acc_nx = (acc_q >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));

   assign bus.in_ready = core_reset_n & ~flush &
                         ((state == IDLE) |
                          ((state == DONE) & bus.out_ready));
   assign bus.out_valid  = valid_q;
   assign bus.out_result = res_q;
   assign bus.out_sign   = sign_q;
`ifdef KV_CSA_RESOLVE_ZERO_FLAG_EN
   assign bus.out_zero   = zero_q;
`endif

   always_ff @(posedge core_clk or negedge core_reset_n) begin
      if (!core_reset_n) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         k_q     <= '0;
         valid_q <= 1'b0;
         sign_q  <= 1'b0;
`ifdef KV_CSA_RESOLVE_ZERO_FLAG_EN
         zacc_q  <= 1'b0;
         zero_q  <= 1'b0;
`endif
      end else if (flush) begin
         state   <= IDLE;
         valid_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q   <= bus.in_sum;
                  b_q   <= bus.in_carry << 1;
                  c_q   <= bus.in_cin;
                  k_q   <= '0;
                  state <= ADD;
`ifdef KV_CSA_RESOLVE_ZERO_FLAG_EN
                  zacc_q <= 1'b1;
`endif
               end
            end
            ADD: begin
               a_q   <= a_q >> CHUNK;
               b_q   <= b_q >> CHUNK;
               c_q   <= co;
               acc_q <= acc_nx;
               k_q   <= k_q + KW'(1);
`ifdef KV_CSA_RESOLVE_ZERO_FLAG_EN
               zacc_q <= zacc_q & ~|s;
`endif
               if (k_q == KLAST) begin
                  state   <= DONE;
                  valid_q <= 1'b1;
                  res_q   <= acc_nx;
                  sign_q  <= acc_nx[WIDTH-1];
`ifdef KV_CSA_RESOLVE_ZERO_FLAG_EN
                  zero_q  <= zacc_q & ~|s;
`endif
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  if (bus.in_valid) begin
                     a_q   <= bus.in_sum;
                     b_q   <= bus.in_carry << 1;
                     c_q   <= bus.in_cin;
                     k_q   <= '0;
                     state <= ADD;
`ifdef KV_CSA_RESOLVE_ZERO_FLAG_EN
                     zacc_q <= 1'b1;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
